// File: rtl/seq_ram_pkg.sv
// Shared types and default sizes for the sequential RAM writer.
package seq_ram_pkg;

    localparam int unsigned DataWDefault = 4;
    localparam int unsigned AddrWDefault = 6;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/sp_ram.sv
// Single-port-write RAM with a registered read address; contents are never reset.
module sp_ram #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [Depth];
    logic [ADDR_W-1:0] raddr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q <= '0;
        end else begin
            raddr_q <= raddr;
        end
    end

    // Combinational read of the stored address: a write shows up right after its edge.
    assign rdata = mem[raddr_q];

endmodule

// File: rtl/seq_ram_writer.sv
// Burst writer: after start, streams len words from a valid/ready input into
// consecutive RAM addresses (wrapping), then pulses done for one cycle.
module seq_ram_writer
    import seq_ram_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned ADDR_W = AddrWDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] q
);

    localparam logic [ADDR_W:0] CntOne = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign beat = wr_valid && wr_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start && (len != '0)) begin
                    state_d = StWrite;
                    ptr_d   = base_addr;
                    cnt_d   = len;
                end
            end
            StWrite: begin
                if (beat) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CntOne) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode state only, so the asynchronous reset clears them at once.
    always_comb begin
        wr_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StWrite: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    sp_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_sp_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (beat),
        .waddr(ptr_q),
        .wdata(wr_data),
        .raddr(rd_addr),
        .rdata(q)
    );

endmodule

// File: tb/tb_seq_ram_writer.sv
// Directed bench for seq_ram_writer with hand-computed expected values.
module tb_seq_ram_writer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] base_addr;
    logic [6:0] len;
    logic       wr_valid;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic       busy;
    logic       done;
    logic [5:0] rd_addr;
    logic [3:0] q;

    int n_checks = 0;
    int n_bad    = 0;

    logic [3:0] bdata [64];

    seq_ram_writer #(
        .DATA_W(4),
        .ADDR_W(6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .q        (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input logic [5:0] a, input logic [3:0] e, input string tag);
        rd_addr = a;
        step();
        check_eq(tag, {28'd0, q}, {28'd0, e});
    endtask

    // Burst with wr_valid held high; returns steps from start until done is seen.
    task automatic burst_held(input logic [5:0] b, input logic [6:0] l, output int cyc);
        int n;
        base_addr = b;
        len       = l;
        start     = 1'b1;
        wr_valid  = 1'b1;
        wr_data   = bdata[0];
        step();
        start = 1'b0;
        n     = 1;
        while (!done && n < 200) begin
            if (n - 1 < 64) wr_data = bdata[n-1];
            step();
            n++;
        end
        wr_valid = 1'b0;
        cyc      = n;
    endtask

    initial begin
        int cyc;
        int vpat [6];
        logic [3:0] dpat [6];

        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_addr = '0;
        #12;
        check_eq("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Sixteen words 0..15 at address 0
        for (int i = 0; i < 16; i++) bdata[i] = 4'(i);
        burst_held(6'd0, 7'd16, cyc);
        check_eq("b16_done_latency", cyc, 32'd17);
        check_eq("b16_ready_in_done", {31'd0, wr_ready}, 32'd0);
        check_eq("b16_busy_in_done", {31'd0, busy}, 32'd1);
        step();
        check_eq("b16_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("b16_idle_done", {31'd0, done}, 32'd0);
        for (int k = 0; k < 16; k++) read_check(6'(k), 4'(k), "b16_read");

        // Wrap from 62 to 1
        bdata[0] = 4'hA; bdata[1] = 4'hB; bdata[2] = 4'hC; bdata[3] = 4'hD;
        burst_held(6'd62, 7'd4, cyc);
        check_eq("wrap_done_latency", cyc, 32'd5);
        step();
        read_check(6'd62, 4'hA, "wrap_m62");
        read_check(6'd63, 4'hB, "wrap_m63");
        read_check(6'd0, 4'hC, "wrap_m0");
        read_check(6'd1, 4'hD, "wrap_m1");
        read_check(6'd2, 4'h2, "wrap_m2_kept");

        // len=3 with wr_valid pattern 1,0,0,1,0,1
        vpat = '{1, 0, 0, 1, 0, 1};
        dpat = '{4'h9, 4'hF, 4'hF, 4'hA, 4'hF, 4'hB};
        base_addr = 6'd4; len = 7'd3; start = 1'b1; wr_valid = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_valid = vpat[i][0];
            wr_data  = dpat[i];
            step();
            if (i < 5) begin
                check_eq("stall_ready", {31'd0, wr_ready}, 32'd1);
                check_eq("stall_no_done", {31'd0, done}, 32'd0);
            end
        end
        check_eq("stall_done", {31'd0, done}, 32'd1);
        wr_valid = 1'b1; wr_data = 4'hF;
        step();
        check_eq("stall_idle_ready", {31'd0, wr_ready}, 32'd0);
        check_eq("stall_idle_busy", {31'd0, busy}, 32'd0);
        step();
        wr_valid = 1'b0;
        read_check(6'd4, 4'h9, "stall_m4");
        read_check(6'd5, 4'hA, "stall_m5");
        read_check(6'd6, 4'hB, "stall_m6");
        read_check(6'd7, 4'h7, "stall_m7_kept");

        // start while busy ignored, start in DONE ignored, next-cycle start accepted
        base_addr = 6'd32; len = 7'd2; start = 1'b1; wr_valid = 1'b0;
        step();
        check_eq("ign_busy", {31'd0, busy}, 32'd1);
        base_addr = 6'd40; len = 7'd5;
        step();
        check_eq("ign_still_write", {31'd0, wr_ready}, 32'd1);
        start = 1'b0; wr_valid = 1'b1; wr_data = 4'h3;
        step();
        check_eq("ign_no_early_done", {31'd0, done}, 32'd0);
        wr_data = 4'h4;
        step();
        check_eq("ign_done_after_2", {31'd0, done}, 32'd1);
        wr_valid = 1'b0; start = 1'b1; base_addr = 6'd48; len = 7'd1;
        step();
        check_eq("start_in_done_ign", {31'd0, busy}, 32'd0);
        check_eq("done_one_cycle", {31'd0, done}, 32'd0);
        step();
        check_eq("b2b_accept", {31'd0, wr_ready}, 32'd1);
        start = 1'b0; wr_valid = 1'b1; wr_data = 4'h6;
        step();
        check_eq("b2b_done", {31'd0, done}, 32'd1);
        wr_valid = 1'b0;
        step();
        start = 1'b1; len = 7'd0; base_addr = 6'd50;
        step();
        check_eq("len0_busy", {31'd0, busy}, 32'd0);
        check_eq("len0_done", {31'd0, done}, 32'd0);
        start = 1'b0;
        step();
        check_eq("len0_busy_after", {31'd0, busy}, 32'd0);
        read_check(6'd32, 4'h3, "ign_m32");
        read_check(6'd33, 4'h4, "ign_m33");
        read_check(6'd48, 4'h6, "b2b_m48");

        // Read-during-write on the held read address
        read_check(6'd5, 4'hA, "rdw_old");
        base_addr = 6'd5; len = 7'd1; start = 1'b1; wr_valid = 1'b1; wr_data = 4'h9;
        step();
        check_eq("rdw_before_edge", {28'd0, q}, 32'hA);
        start = 1'b0;
        step();
        check_eq("rdw_new", {28'd0, q}, 32'h9);
        check_eq("rdw_done", {31'd0, done}, 32'd1);
        wr_valid = 1'b0;
        step();

        // Reset after 2 of 8 beats
        base_addr = 6'd8; len = 7'd8; start = 1'b1; wr_valid = 1'b1; wr_data = 4'hE;
        step();
        start = 1'b0;
        step();
        wr_data = 4'hD;
        step();
        wr_data = 4'hC;
        rd_addr = 6'd9;
        #2 rst_n = 1'b0;
        #1;
        check_eq("mrst_ready", {31'd0, wr_ready}, 32'd0);
        check_eq("mrst_busy", {31'd0, busy}, 32'd0);
        check_eq("mrst_done", {31'd0, done}, 32'd0);
        check_eq("mrst_raddr_zero", {28'd0, q}, 32'hC);
        start = 1'b1; len = 7'd4;
        step();
        step();
        check_eq("mrst_no_start", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        check_eq("mrst_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("mrst_idle_ready", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b0;
        read_check(6'd8, 4'hE, "mrst_m8");
        read_check(6'd9, 4'hD, "mrst_m9");
        read_check(6'd10, 4'hA, "mrst_m10_kept");
        read_check(6'd15, 4'hF, "mrst_m15_kept");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_ram_writer.md
SEQ_RAM_WRITER -- requirements
Module: seq_ram_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 4, word width.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; depth = 2**ADDR_W (64).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W, first write address; captured with start.
REQ-007 SHALL have port len, input, ADDR_W+1, number of words to write (1..64); captured with start.
REQ-008 SHALL have port wr_valid, input, 1, write-data word valid.
REQ-009 SHALL have port wr_data, input, DATA_W, write-data word.
REQ-010 SHALL have port wr_ready, output, 1, block accepts wr_data this cycle.
REQ-011 SHALL have port busy, output, 1, burst in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after last word is written.
REQ-013 SHALL have port rd_addr, input, ADDR_W, read address.
REQ-014 SHALL have port q, output, DATA_W, read data.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-016 IDLE->WRITE when start=1 and len!=0; start with len=0 SHALL be ignored (remain IDLE, no done).
REQ-017 WRITE: wr_ready=1; a beat SHALL transfer only when wr_valid=1 and wr_ready=1.
REQ-018 Each beat SHALL write wr_data to mem[ptr], increment ptr mod 2**ADDR_W (63->0 wrap), decrement remaining count.
REQ-019 Beat with remaining count=1 SHALL move WRITE->DONE; DONE SHALL last exactly one cycle with done=1, then IDLE.
REQ-020 wr_ready SHALL be 0 in IDLE and DONE; wr_valid there SHALL cause no write.
REQ-021 busy SHALL be 1 in WRITE and DONE, 0 in IDLE.
REQ-022 start asserted while busy SHALL be ignored; base_addr/len changes during a burst SHALL have no effect.
REQ-023 wr_valid deasserted mid-burst SHALL stall without timeout; no write, ptr and count hold.
REQ-024 Read port: rd_addr SHALL be registered every cycle regardless of state; q = mem[registered address] (1-cycle read latency).
REQ-025 A write to the address held in the read-address register SHALL be visible on q the cycle after the write edge.
REQ-026 Back-to-back bursts: start in the cycle after DONE SHALL be accepted.

Reset
REQ-027 rst_n low SHALL force IDLE, ptr=0, count=0, registered read address=0; wr_ready=0, busy=0, done=0 immediately (asynchronous).
REQ-028 Memory contents SHALL NOT be cleared by reset; reset mid-burst SHALL abandon the burst, keeping words already written.
REQ-029 Deassertion of rst_n SHALL take effect on the next posedge clk; no start accepted before it.

Structure
REQ-030 FSM state enum and default DATA_W/ADDR_W constants SHALL reside in shared package seq_ram_pkg.
REQ-031 Storage SHALL be one sub-module sp_ram (one write port, registered-address read port); controller FSM, pointer and counter stay in seq_ram_writer.

Verification
REQ-032 Reset then start, base_addr=0, len=16, wr_data 0..15 with wr_valid held -> done pulse 17 cycles after start; rd_addr=k gives q=k one cycle later for k=0..15.
REQ-033 base_addr=62, len=4, data A,B,C,D -> mem[62]=A, mem[63]=B, mem[0]=C, mem[1]=D; mem[2] unchanged.
REQ-034 len=3 with wr_valid toggled 1,0,0,1,0,1 -> exactly 3 writes, done one cycle after third accepted beat, wr_ready=0 in following IDLE.
REQ-035 start during burst, and start with len=0 in IDLE -> ignored; busy/done and memory unaffected.
REQ-036 rst_n asserted after 2 of 8 beats -> outputs zero immediately, IDLE after release, first 2 words readable, remaining addresses unchanged.
REQ-037 rd_addr held at 5 while writing 9 to address 5 -> q shows old value, then 9 one cycle after write edge.
